// File: rtl/modn_ctrl_pkg.sv
// Shared definitions for the mod-N sweep controller: state encoding, default
// sizing and a step-distance helper for benches and host-side models.
package modn_ctrl_pkg;

    localparam int N_DEFAULT     = 10;
    localparam int MSB_DEFAULT   = 4;
    localparam int LAPW_DEFAULT  = 3;
    localparam int STEPW_DEFAULT = 12;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2,
        S_FIN  = 2'd3
    } state_t;

    // Directed distance start->target on a ring of n values, plus full extra laps.
    function automatic int step_distance(input int start, input int target,
                                         input bit up, input int laps, input int n);
        int d;
        if (up) d = (target - start + n) % n;
        else    d = (start - target + n) % n;
        return d + laps * n;
    endfunction

endpackage

// File: rtl/modn_sweep_ctrl_if.sv
// Command, status and counter-control bundle between a host, the sweep
// controller and the mod-N counter datapath.
interface modn_sweep_ctrl_if
    import modn_ctrl_pkg::*;
#(
    parameter int MSB   = MSB_DEFAULT,
    parameter int LAPW  = LAPW_DEFAULT,
    parameter int STEPW = STEPW_DEFAULT
) ();

    logic             cmd_valid;
    logic             cmd_ready;
    logic [MSB-1:0]   cmd_target;
    logic             cmd_up;
    logic [LAPW-1:0]  cmd_laps;
    logic             cmd_preset;
    logic [MSB-1:0]   cmd_start;
    logic             abort;
    logic [MSB-1:0]   ctr_count;
    logic             ctr_en;
    logic             ctr_up;
    logic             ctr_load;
    logic [MSB-1:0]   ctr_load_val;
    logic             busy;
    logic             done;
    logic             aborted;
    logic             err;
    logic [STEPW-1:0] steps;

    modport master (
        output cmd_valid, cmd_target, cmd_up, cmd_laps, cmd_preset, cmd_start,
               abort, ctr_count,
        input  cmd_ready, ctr_en, ctr_up, ctr_load, ctr_load_val,
               busy, done, aborted, err, steps
    );

    modport slave (
        input  cmd_valid, cmd_target, cmd_up, cmd_laps, cmd_preset, cmd_start,
               abort, ctr_count,
        output cmd_ready, ctr_en, ctr_up, ctr_load, ctr_load_val,
               busy, done, aborted, err, steps
    );

endinterface

// File: rtl/modn_lap_tracker.sv
// Remaining-lap bookkeeping and the target compare that decides when a sweep
// stops: the target must be hit once more after all extra laps are used up.
module modn_lap_tracker
    import modn_ctrl_pkg::*;
#(
    parameter int MSB  = MSB_DEFAULT,
    parameter int LAPW = LAPW_DEFAULT
) (
    input  logic            clk,
    input  logic            arst,
    input  logic [MSB-1:0]  ctr_count,
    input  logic [MSB-1:0]  target,
    input  logic            load,
    input  logic [LAPW-1:0] laps,
    input  logic            step,
    output logic            hit,
    output logic            stop
);

    logic [LAPW-1:0] laps_rem;

    assign hit  = (ctr_count == target);
    assign stop = hit && (laps_rem == '0);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            laps_rem <= '0;
        end else if (load) begin
            laps_rem <= laps;
        end else if (step && hit && (laps_rem != '0)) begin
            laps_rem <= laps_rem - LAPW'(1);
        end
    end

endmodule

// File: rtl/modn_sweep_ctrl.sv
// Sweep sequencer: accepts one command, optionally presets the counter, runs it
// until the target is reached after the requested laps, then reports steps.
module modn_sweep_ctrl
    import modn_ctrl_pkg::*;
#(
    parameter int N     = N_DEFAULT,
    parameter int MSB   = MSB_DEFAULT,
    parameter int LAPW  = LAPW_DEFAULT,
    parameter int STEPW = STEPW_DEFAULT
) (
    input  logic          clk,
    input  logic          arst,
    modn_sweep_ctrl_if.slave bus
);

    localparam logic [MSB:0] N_LIMIT = (MSB+1)'(N);

    state_t           state;
    state_t           state_next;
    logic [MSB-1:0]   target_q;
    logic [MSB-1:0]   start_q;
    logic             up_q;
    logic [STEPW-1:0] steps_q;
    logic             done_q;
    logic             aborted_q;
    logic             err_q;

    logic accept;
    logic cmd_bad;
    logic cmd_ok;
    logic in_run;
    logic run_en;
    logic hit;
    logic stop;

    assign accept = (state == S_IDLE) && bus.cmd_valid;
    assign cmd_bad = ({1'b0, bus.cmd_target} >= N_LIMIT) ||
                     (bus.cmd_preset && ({1'b0, bus.cmd_start} >= N_LIMIT));
    assign cmd_ok = accept && !cmd_bad;
    assign in_run = (state == S_RUN);
    assign run_en = in_run && !stop && !bus.abort;

    modn_lap_tracker #(.MSB(MSB), .LAPW(LAPW)) u_lap_tracker (
        .clk       (clk),
        .arst      (arst),
        .ctr_count (bus.ctr_count),
        .target    (target_q),
        .load      (cmd_ok),
        .laps      (bus.cmd_laps),
        .step      (in_run),
        .hit       (hit),
        .stop      (stop)
    );

    always_ff @(posedge clk or posedge arst) begin
        if (arst) state <= S_IDLE;
        else      state <= state_next;
    end

    always_comb begin
        // NOTE: every signal written here gets a default first so no path infers a latch.
        state_next = state;
        case (state)
            S_IDLE: if (cmd_ok) state_next = bus.cmd_preset ? S_LOAD : S_RUN;
            S_LOAD: state_next = S_RUN;
            S_RUN: begin
                // Abort wins over a simultaneous stop: the sweep ends without done.
                if (bus.abort)  state_next = S_IDLE;
                else if (stop)  state_next = S_FIN;
            end
            S_FIN:   state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            target_q  <= '0;
            start_q   <= '0;
            up_q      <= 1'b0;
            steps_q   <= '0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            done_q    <= (state == S_FIN);
            aborted_q <= in_run && bus.abort;
            err_q     <= accept && cmd_bad;
            if (cmd_ok) begin
                target_q <= bus.cmd_target;
                start_q  <= bus.cmd_start;
                up_q     <= bus.cmd_up;
                steps_q  <= '0;
            end else if (run_en && (steps_q != '1)) begin
                steps_q <= steps_q + STEPW'(1);
            end
        end
    end

    assign bus.cmd_ready    = (state == S_IDLE);
    assign bus.busy         = (state != S_IDLE);
    assign bus.ctr_en       = run_en;
    assign bus.ctr_up       = (state != S_IDLE) && up_q;
    assign bus.ctr_load     = (state == S_LOAD);
    assign bus.ctr_load_val = (state == S_LOAD) ? start_q : '0;
    assign bus.done         = done_q;
    assign bus.aborted      = aborted_q;
    assign bus.err          = err_q;
    assign bus.steps        = steps_q;

    assert property (@(posedge clk) disable iff (arst) stop |-> hit);

endmodule

// File: tb/tb_modn_sweep_ctrl.sv
// Self-checking bench for modn_sweep_ctrl: a behavioural mod-10 counter closes
// the loop, and expectations come from ring-distance arithmetic.
module tb_modn_sweep_ctrl;

    localparam int N = 10;

    logic       clk  = 1'b0;
    logic       arst = 1'b1;
    logic [3:0] cnt  = 4'd0;

    int total = 0;
    int bad   = 0;

    int          o_en_cnt, o_load_cnt, o_busy_cnt, o_done_cnt, o_abort_cnt, o_err_cnt;
    int          o_done_obs, o_err_obs, o_excl_bad;
    logic [3:0]  o_load_val;
    logic [11:0] o_steps;
    logic        o_ready, o_ready_end, o_en_at_abort, o_timeout;

    always #5 clk = ~clk;

    modn_sweep_ctrl_if #(.MSB(4), .LAPW(3), .STEPW(12)) bus ();

    modn_sweep_ctrl #(.N(N), .MSB(4), .LAPW(3), .STEPW(12)) dut (
        .clk  (clk),
        .arst (arst),
        .bus  (bus)
    );

    assign bus.ctr_count = cnt;

    // Counter datapath model: load has priority, wrap is mod N.
    always @(posedge clk) begin
        if (bus.ctr_load)
            cnt <= bus.ctr_load_val;
        else if (bus.ctr_en)
            cnt <= bus.ctr_up ? ((cnt == 4'd9) ? 4'd0 : cnt + 4'd1)
                              : ((cnt == 4'd0) ? 4'd9 : cnt - 4'd1);
    end

    function automatic int exp_dist(input int s, input int t, input bit up, input int l);
        return (up ? (t - s + N) % N : (s - t + N) % N) + l * N;
    endfunction

    function automatic int moved(input int s, input bit up, input int k);
        return up ? (s + k) % N : (((s - k) % N) + N) % N;
    endfunction

    // Offers one command at the current negedge and records what happens until
    // done/aborted/err plus 'tail' more cycles. abort_at<0 means never abort.
    task automatic run_sweep(input logic pre, input logic [3:0] st, input logic [3:0] tg,
                             input logic up, input logic [2:0] lp,
                             input int abort_at, input int tail);
        int obs;
        int extra;
        bit ended;
        bit abort_issued;
        o_en_cnt = 0; o_load_cnt = 0; o_busy_cnt = 0; o_done_cnt = 0; o_abort_cnt = 0;
        o_err_cnt = 0; o_done_obs = -1; o_err_obs = -1; o_excl_bad = 0;
        o_load_val = '0; o_steps = '0; o_timeout = 1'b0; o_en_at_abort = 1'bx;
        o_ready_end = 1'b0;
        bus.cmd_valid  = 1'b1;
        bus.cmd_preset = pre;
        bus.cmd_start  = st;
        bus.cmd_target = tg;
        bus.cmd_up     = up;
        bus.cmd_laps   = lp;
        o_ready = bus.cmd_ready;
        @(negedge clk);
        bus.cmd_valid  = 1'b0;
        bus.cmd_target = 4'($urandom_range(0, 15));
        bus.cmd_start  = 4'($urandom_range(0, 15));
        obs = 0; extra = 0; ended = 1'b0; abort_issued = 1'b0;
        while (1) begin
            obs++;
            if (!ended && abort_at >= 0 && !abort_issued && obs >= (pre ? 2 : 1) &&
                o_en_cnt == abort_at) begin
                bus.abort = 1'b1;
                abort_issued = 1'b1;
            end else begin
                bus.abort = 1'b0;
            end
            #1;
            if (bus.abort) o_en_at_abort = bus.ctr_en;
            if (bus.ctr_en) o_en_cnt++;
            if (bus.ctr_load) begin o_load_cnt++; o_load_val = bus.ctr_load_val; end
            if (bus.busy) o_busy_cnt++;
            if (bus.done) begin o_done_cnt++; if (o_done_obs < 0) o_done_obs = obs; end
            if (bus.aborted) o_abort_cnt++;
            if (bus.err) begin o_err_cnt++; if (o_err_obs < 0) o_err_obs = obs; end
            if (int'(bus.done) + int'(bus.aborted) + int'(bus.err) > 1) o_excl_bad++;
            if (!ended && (bus.done || bus.aborted || bus.err)) begin
                ended = 1'b1;
                o_steps = bus.steps;
                o_ready_end = bus.cmd_ready;
            end
            if (ended) begin
                if (extra >= tail) break;
                extra++;
            end else if (obs >= 200) begin
                o_timeout = 1'b1;
                break;
            end
            @(negedge clk);
        end
        bus.abort = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        total++; if (bus.cmd_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", bus.cmd_ready); end
        total++; if (bus.ctr_en !== 1'b0) begin bad++; $display("FAIL reset_ctr_en got=%b want=0", bus.ctr_en); end
        total++; if (bus.ctr_load !== 1'b0) begin bad++; $display("FAIL reset_ctr_load got=%b want=0", bus.ctr_load); end
        total++; if (bus.ctr_up !== 1'b0) begin bad++; $display("FAIL reset_ctr_up got=%b want=0", bus.ctr_up); end
        total++; if (bus.ctr_load_val !== 4'd0) begin bad++; $display("FAIL reset_load_val got=%0d want=0", bus.ctr_load_val); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", bus.busy); end
        total++; if ({bus.done, bus.aborted, bus.err} !== 3'b000) begin bad++; $display("FAIL reset_pulses got=%b want=000", {bus.done, bus.aborted, bus.err}); end
        total++; if (bus.steps !== 12'd0) begin bad++; $display("FAIL reset_steps got=%0d want=0", bus.steps); end
        @(negedge clk);
        arst = 1'b0;
        @(negedge clk);
        #1;
        total++; if (bus.busy !== 1'b0 || bus.cmd_ready !== 1'b1) begin bad++; $display("FAIL post_reset_idle busy=%b ready=%b want 0/1", bus.busy, bus.cmd_ready); end
    endtask

    task automatic test_preset_up();
        run_sweep(1'b1, 4'd3, 4'd7, 1'b1, 3'd0, -1, 2);
        total++; if (o_timeout !== 1'b0) begin bad++; $display("FAIL up_timeout got=%b want=0", o_timeout); end
        total++; if (o_load_cnt !== 1 || o_load_val !== 4'd3) begin bad++; $display("FAIL up_load cycles=%0d val=%0d want 1/3", o_load_cnt, o_load_val); end
        total++; if (o_en_cnt !== 4) begin bad++; $display("FAIL up_en_cycles got=%0d want=4", o_en_cnt); end
        total++; if (o_steps !== 12'd4) begin bad++; $display("FAIL up_steps got=%0d want=4", o_steps); end
        total++; if (cnt !== 4'd7) begin bad++; $display("FAIL up_count got=%0d want=7", cnt); end
        total++; if (o_done_cnt !== 1 || o_abort_cnt !== 0) begin bad++; $display("FAIL up_done done=%0d aborted=%0d want 1/0", o_done_cnt, o_abort_cnt); end
        total++; if (o_done_obs !== 2 + 4 + 2) begin bad++; $display("FAIL up_done_time got=%0d want=8", o_done_obs); end
    endtask

    task automatic test_preset_down_wrap();
        run_sweep(1'b1, 4'd3, 4'd7, 1'b0, 3'd0, -1, 2);
        total++; if (o_steps !== 12'd6 || o_en_cnt !== 6) begin bad++; $display("FAIL down_steps got=%0d en=%0d want=6", o_steps, o_en_cnt); end
        total++; if (cnt !== 4'd7) begin bad++; $display("FAIL down_count got=%0d want=7", cnt); end
        total++; if (o_done_cnt !== 1) begin bad++; $display("FAIL down_done got=%0d want=1", o_done_cnt); end
    endtask

    task automatic test_laps_same_target();
        run_sweep(1'b1, 4'd5, 4'd5, 1'b1, 3'd1, -1, 2);
        total++; if (o_steps !== 12'd10 || cnt !== 4'd5) begin bad++; $display("FAIL lap_steps got=%0d count=%0d want 10/5", o_steps, cnt); end
        run_sweep(1'b1, 4'd5, 4'd5, 1'b1, 3'd0, -1, 2);
        total++; if (o_steps !== 12'd0 || o_en_cnt !== 0) begin bad++; $display("FAIL zero_steps got=%0d en=%0d want 0", o_steps, o_en_cnt); end
        total++; if (o_done_obs !== 4 || o_done_cnt !== 1) begin bad++; $display("FAIL zero_done_time got=%0d n=%0d want 4/1", o_done_obs, o_done_cnt); end
    endtask

    task automatic test_err();
        run_sweep(1'b0, 4'd0, 4'd12, 1'b1, 3'd0, -1, 2);
        total++; if (o_err_obs !== 1 || o_err_cnt !== 1) begin bad++; $display("FAIL err_target at=%0d n=%0d want 1/1", o_err_obs, o_err_cnt); end
        total++; if (o_en_cnt !== 0 || o_load_cnt !== 0 || o_busy_cnt !== 0) begin bad++; $display("FAIL err_target_quiet en=%0d load=%0d busy=%0d want 0", o_en_cnt, o_load_cnt, o_busy_cnt); end
        total++; if (o_ready_end !== 1'b1) begin bad++; $display("FAIL err_ready got=%b want=1", o_ready_end); end
        run_sweep(1'b1, 4'd11, 4'd4, 1'b1, 3'd0, -1, 2);
        total++; if (o_err_obs !== 1 || o_en_cnt !== 0 || o_load_cnt !== 0 || o_busy_cnt !== 0) begin bad++; $display("FAIL err_start at=%0d en=%0d load=%0d busy=%0d want 1/0/0/0", o_err_obs, o_en_cnt, o_load_cnt, o_busy_cnt); end
    endtask

    task automatic test_back_to_back();
        run_sweep(1'b1, 4'd0, 4'd9, 1'b1, 3'd2, 5, 0);
        total++; if (o_en_at_abort !== 1'b0) begin bad++; $display("FAIL abort_en got=%b want=0", o_en_at_abort); end
        total++; if (cnt !== 4'd5 || o_steps !== 12'd5) begin bad++; $display("FAIL abort_state count=%0d steps=%0d want 5/5", cnt, o_steps); end
        total++; if (o_abort_cnt !== 1 || o_done_cnt !== 0) begin bad++; $display("FAIL abort_pulses aborted=%0d done=%0d want 1/0", o_abort_cnt, o_done_cnt); end
        run_sweep(1'b0, 4'd0, 4'd8, 1'b1, 3'd0, -1, 2);
        total++; if (o_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready got=%b want=1", o_ready); end
        total++; if (o_steps !== 12'd3 || cnt !== 4'd8 || o_done_cnt !== 1) begin bad++; $display("FAIL b2b_sweep steps=%0d count=%0d done=%0d want 3/8/1", o_steps, cnt, o_done_cnt); end
    endtask

    task automatic test_arst_mid_run();
        int s;
        int e;
        bus.cmd_valid = 1'b1; bus.cmd_preset = 1'b1; bus.cmd_start = 4'd0;
        bus.cmd_target = 4'd9; bus.cmd_up = 1'b1; bus.cmd_laps = 3'd2;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        repeat (4) @(negedge clk);
        #1;
        total++; if (bus.ctr_en !== 1'b1 || bus.steps !== 12'd3) begin bad++; $display("FAIL arst_pre en=%b steps=%0d want 1/3", bus.ctr_en, bus.steps); end
        #2;
        arst = 1'b1;
        #1;
        total++; if (bus.ctr_en !== 1'b0 || bus.ctr_load !== 1'b0 || bus.busy !== 1'b0) begin bad++; $display("FAIL arst_drop en=%b load=%b busy=%b want 0", bus.ctr_en, bus.ctr_load, bus.busy); end
        total++; if (bus.steps !== 12'd0 || bus.cmd_ready !== 1'b1) begin bad++; $display("FAIL arst_state steps=%0d ready=%b want 0/1", bus.steps, bus.cmd_ready); end
        @(negedge clk);
        arst = 1'b0;
        #1;
        total++; if ({bus.done, bus.aborted} !== 2'b00 || cnt !== 4'd3) begin bad++; $display("FAIL arst_after pulses=%b count=%0d want 00/3", {bus.done, bus.aborted}, cnt); end
        s = int'(cnt);
        e = exp_dist(s, 2, 1'b0, 1);
        run_sweep(1'b0, 4'd0, 4'd2, 1'b0, 3'd1, -1, 2);
        total++; if (int'(o_steps) !== e || cnt !== 4'd2 || o_done_cnt !== 1) begin bad++; $display("FAIL arst_resweep steps=%0d count=%0d done=%0d want %0d/2/1", o_steps, cnt, o_done_cnt, e); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 24; i++) begin
            int kind;
            logic pre;
            logic up;
            logic [3:0] st;
            logic [3:0] tg;
            logic [2:0] lp;
            int s;
            int e;
            int k;
            kind = int'($urandom_range(0, 7));
            pre  = 1'($urandom_range(0, 1));
            up   = 1'($urandom_range(0, 1));
            st   = 4'($urandom_range(0, 9));
            tg   = 4'($urandom_range(0, 9));
            lp   = 3'($urandom_range(0, 3));
            if (kind == 0) begin
                if (pre && $urandom_range(0, 1) == 1) st = 4'($urandom_range(10, 15));
                else                                  tg = 4'($urandom_range(10, 15));
                run_sweep(pre, st, tg, up, lp, -1, 2);
                total++; if (o_err_cnt !== 1 || o_en_cnt !== 0 || o_load_cnt !== 0 || o_busy_cnt !== 0) begin bad++; $display("FAIL rnd%0d_err err=%0d en=%0d load=%0d busy=%0d want 1/0/0/0", i, o_err_cnt, o_en_cnt, o_load_cnt, o_busy_cnt); end
            end else begin
                s = pre ? int'(st) : int'(cnt);
                e = exp_dist(s, int'(tg), up, int'(lp));
                if (kind == 1 && e > 0) begin
                    k = int'($urandom_range(0, e - 1));
                    run_sweep(pre, st, tg, up, lp, k, 2);
                    total++; if (int'(o_steps) !== k || int'(cnt) !== moved(s, up, k)) begin bad++; $display("FAIL rnd%0d_abort steps=%0d count=%0d want %0d/%0d", i, o_steps, cnt, k, moved(s, up, k)); end
                    total++; if (o_abort_cnt !== 1 || o_done_cnt !== 0) begin bad++; $display("FAIL rnd%0d_abort_pulse aborted=%0d done=%0d want 1/0", i, o_abort_cnt, o_done_cnt); end
                end else begin
                    run_sweep(pre, st, tg, up, lp, -1, 2);
                    total++; if (int'(o_steps) !== e || o_en_cnt !== e) begin bad++; $display("FAIL rnd%0d_steps got=%0d en=%0d want=%0d", i, o_steps, o_en_cnt, e); end
                    total++; if (cnt !== tg || o_done_cnt !== 1) begin bad++; $display("FAIL rnd%0d_end count=%0d done=%0d want %0d/1", i, cnt, o_done_cnt, tg); end
                    total++; if (o_done_obs !== (pre ? 2 : 1) + e + 2 || o_load_cnt !== int'(pre)) begin bad++; $display("FAIL rnd%0d_timing done_at=%0d load=%0d want %0d/%0d", i, o_done_obs, o_load_cnt, (pre ? 2 : 1) + e + 2, int'(pre)); end
                end
            end
            total++; if (o_excl_bad !== 0 || o_timeout !== 1'b0) begin bad++; $display("FAIL rnd%0d_sanity overlap=%0d timeout=%b want 0/0", i, o_excl_bad, o_timeout); end
        end
    endtask

    initial begin
        bus.cmd_valid  = 1'b0;
        bus.cmd_target = 4'd0;
        bus.cmd_up     = 1'b0;
        bus.cmd_laps   = 3'd0;
        bus.cmd_preset = 1'b0;
        bus.cmd_start  = 4'd0;
        bus.abort      = 1'b0;
        test_reset();
        test_preset_up();
        test_preset_down_wrap();
        test_laps_same_target();
        test_err();
        test_back_to_back();
        test_arst_mid_run();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
